// File: rtl/move_expander_pkg.sv
// Shared definitions for the 8-puzzle successor generator: move and ALU
// encodings, board field positions, the default goal board and small helpers.
package move_expander_pkg;

  typedef enum logic [2:0] {
    MV_NONE  = 3'd0,
    MV_UP    = 3'd1,
    MV_DOWN  = 3'd2,
    MV_LEFT  = 3'd3,
    MV_RIGHT = 3'd4
  } move_t;

  typedef enum logic [3:0] {
    OP_COPY     = 4'd0,
    OP_TO_UP    = 4'd1,
    OP_TO_DOWN  = 4'd2,
    OP_TO_LEFT  = 4'd3,
    OP_TO_RIGHT = 4'd4
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_EXPAND,
    ST_EMIT
  } state_t;

  // Blank index lives in the top nibble; tiles follow row-major from bit 35.
  localparam int BLANK_MSB = 39;
  localparam int BLANK_LSB = 36;
  localparam logic [3:0] MAX_BLANK = 4'd8;

  localparam logic [39:0] DEFAULT_GOAL = 40'h8123456780;

  // The move that would undo the given one; NONE has no reverse.
  function automatic move_t reverse_move(input move_t m);
    case (m)
      MV_UP:    reverse_move = MV_DOWN;
      MV_DOWN:  reverse_move = MV_UP;
      MV_LEFT:  reverse_move = MV_RIGHT;
      MV_RIGHT: reverse_move = MV_LEFT;
      default:  reverse_move = MV_NONE;
    endcase
  endfunction

  // Expansion order is UP, DOWN, LEFT, RIGHT.
  function automatic move_t next_move(input move_t m);
    case (m)
      MV_UP:   next_move = MV_DOWN;
      MV_DOWN: next_move = MV_LEFT;
      default: next_move = MV_RIGHT;
    endcase
  endfunction

  function automatic alu_op_t move_to_op(input move_t m);
    case (m)
      MV_UP:    move_to_op = OP_TO_UP;
      MV_DOWN:  move_to_op = OP_TO_DOWN;
      MV_LEFT:  move_to_op = OP_TO_LEFT;
      MV_RIGHT: move_to_op = OP_TO_RIGHT;
      default:  move_to_op = OP_COPY;
    endcase
  endfunction

endpackage

// File: rtl/move_expander_legal.sv
// Decides whether a move is legal for a blank position, excluding moves that
// would simply undo the move that produced the parent.
module move_legal
  import move_expander_pkg::*;
(
  input  logic [3:0] blank,
  input  move_t      move,
  input  move_t      last_move,
  output logic       legal
);

  logic [3:0] col;

  assign col = blank % 4'd3;

  // Edge-of-board checks first, then suppress the reversing move.
  always_comb begin
    legal = 1'b0;
    case (move)
      MV_UP:    legal = (blank >= 4'd3);
      MV_DOWN:  legal = (blank <= 4'd5);
      MV_LEFT:  legal = (col != 4'd0);
      MV_RIGHT: legal = (col != 4'd2);
      default:  legal = 1'b0;
    endcase
    if (move == reverse_move(last_move)) begin
      legal = 1'b0;
    end
  end

endmodule

// File: rtl/move_expander.sv
// Successor sequencer: takes one parent board, does the goal/error/depth
// checks, then walks UP, DOWN, LEFT, RIGHT driving the move ALU and handing
// each legal child downstream over valid/ready.
module move_expander
  import move_expander_pkg::*;
#(
  parameter logic [39:0] GOAL      = DEFAULT_GOAL,
  parameter logic [7:0]  MAX_DEPTH = 8'd31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [39:0] in_board,
  input  logic [2:0]  in_last_move,
  input  logic [7:0]  in_depth,
  output logic [3:0]  alu_op,
  output logic [39:0] alu_in1,
  input  logic [39:0] alu_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [39:0] out_board,
  output logic [2:0]  out_move,
  output logic [7:0]  out_depth,
  output logic        goal_found,
  input  logic        goal_clr,
  output logic        done,
  output logic        err
);

  state_t      state;
  logic [39:0] board_q;
  move_t       last_q;
  logic [7:0]  depth_q;
  move_t       move_idx;
  logic        legal;
  logic [3:0]  blank;

  assign blank   = board_q[BLANK_MSB:BLANK_LSB];
  assign alu_in1 = board_q;

  // Held low while reset is asserted so nothing is accepted mid-reset.
  assign in_ready = rst_n && (state == ST_IDLE) && !goal_found;

  move_legal u_legal (
    .blank     (blank),
    .move      (move_idx),
    .last_move (last_q),
    .legal     (legal)
  );

  // The ALU is combinational, so the opcode is only asserted in the EXPAND
  // cycle whose result gets captured into out_board.
  always_comb begin
    alu_op = OP_COPY;
    if ((state == ST_EXPAND) && legal) begin
      alu_op = move_to_op(move_idx);
    end
  end

  // Main sequencer: parent capture, early-exit checks, move walk and output
  // handshake, with done/err as single-cycle registered pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      board_q    <= '0;
      last_q     <= MV_NONE;
      depth_q    <= '0;
      move_idx   <= MV_UP;
      out_valid  <= 1'b0;
      out_board  <= '0;
      out_move   <= '0;
      out_depth  <= '0;
      goal_found <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (goal_clr) begin
        goal_found <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            board_q  <= in_board;
            last_q   <= move_t'(in_last_move);
            depth_q  <= in_depth;
            move_idx <= MV_UP;
            state    <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (blank > MAX_BLANK) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= ST_IDLE;
          end else if (board_q == GOAL) begin
            if (!goal_clr) begin
              goal_found <= 1'b1;
            end
            done  <= 1'b1;
            state <= ST_IDLE;
          end else if (depth_q == MAX_DEPTH) begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end else begin
            state <= ST_EXPAND;
          end
        end
        ST_EXPAND: begin
          if (legal) begin
            out_board <= alu_out;
            out_move  <= move_idx;
            out_depth <= depth_q + 8'd1;
            out_valid <= 1'b1;
            state     <= ST_EMIT;
          end else if (move_idx == MV_RIGHT) begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end else begin
            move_idx <= next_move(move_idx);
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (move_idx == MV_RIGHT) begin
              done  <= 1'b1;
              state <= ST_IDLE;
            end else begin
              move_idx <= next_move(move_idx);
              state    <= ST_EXPAND;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_move_expander.sv
// Bench for move_expander: a behavioural move ALU, a table of parent boards
// with hand-computed children and done timing, plus hand-written sequences
// for stalls, mid-operation reset and the sticky goal flag.
module tb_move_expander;
  import move_expander_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [39:0] in_board;
  logic [2:0]  in_last_move;
  logic [7:0]  in_depth;
  logic [3:0]  alu_op;
  logic [39:0] alu_in1;
  logic [39:0] alu_out;
  logic        out_valid;
  logic        out_ready;
  logic [39:0] out_board;
  logic [2:0]  out_move;
  logic [7:0]  out_depth;
  logic        goal_found;
  logic        goal_clr;
  logic        done;
  logic        err;

  int total = 0;
  int bad   = 0;

  move_expander dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_board     (in_board),
    .in_last_move (in_last_move),
    .in_depth     (in_depth),
    .alu_op       (alu_op),
    .alu_in1      (alu_in1),
    .alu_out      (alu_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_board    (out_board),
    .out_move     (out_move),
    .out_depth    (out_depth),
    .goal_found   (goal_found),
    .goal_clr     (goal_clr),
    .done         (done),
    .err          (err)
  );

  // 10 ns clock, rising edge active.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural move ALU: swap the blank with the neighbouring tile.
  int          alu_b;
  int          alu_nb;
  logic [3:0]  alu_tile;
  always_comb begin
    alu_out  = alu_in1;
    alu_b    = int'(alu_in1[39:36]);
    alu_nb   = alu_b;
    alu_tile = 4'd0;
    case (alu_op)
      OP_TO_UP:    alu_nb = alu_b - 3;
      OP_TO_DOWN:  alu_nb = alu_b + 3;
      OP_TO_LEFT:  alu_nb = alu_b - 1;
      OP_TO_RIGHT: alu_nb = alu_b + 1;
      default:     alu_nb = alu_b;
    endcase
    if (alu_op != OP_COPY && alu_b <= 8 && alu_nb >= 0 && alu_nb <= 8) begin
      alu_tile = alu_in1[35-4*alu_nb -: 4];
      alu_out[35-4*alu_b -: 4]  = alu_tile;
      alu_out[35-4*alu_nb -: 4] = 4'd0;
      alu_out[39:36]            = alu_nb[3:0];
    end
  end

  typedef struct {
    logic [39:0]       board;
    logic [2:0]        last;
    logic [7:0]        depth;
    int                n_children;
    logic [3:0][39:0]  child;
    logic [3:0][2:0]   cmove;
    int                done_cycle;
    logic              exp_err;
  } vec_t;

  vec_t vecs[5];

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offer one parent and return at the falling edge after it is accepted.
  task automatic apply_stimulus(input logic [39:0] board, input logic [2:0] last, input logic [7:0] depth);
    @(negedge clk);
    check_output("in_ready_before_accept", 64'(in_ready), 64'd1);
    in_valid     = 1'b1;
    in_board     = board;
    in_last_move = last;
    in_depth     = depth;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_vector(input vec_t v);
    int   k;
    int   done_at;
    logic err_seen;
    k        = 0;
    done_at  = -1;
    err_seen = 1'b0;
    apply_stimulus(v.board, v.last, v.depth);
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (out_valid) begin
        if (k < 4) begin
          check_output("child_board", 64'(out_board), 64'(v.child[k]));
          check_output("child_move", 64'(out_move), 64'(v.cmove[k]));
          check_output("child_depth", 64'(out_depth), 64'(v.depth + 8'd1));
        end
        k++;
      end
      if (err) err_seen = 1'b1;
      if (done) begin
        done_at = c;
        break;
      end
    end
    check_output("done_cycle", 64'(done_at), 64'(v.done_cycle));
    check_output("child_count", 64'(k), 64'(v.n_children));
    check_output("err_pulse", 64'(err_seen), 64'(v.exp_err));
    check_output("in_ready_after_done", 64'(in_ready), 64'd1);
    @(negedge clk);
    check_output("done_one_cycle", 64'(done), 64'd0);
  endtask

  // Safety net so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic seen;

    vecs[0] = '{board: 40'h4123804765, last: 3'd0, depth: 8'd3, n_children: 4,
                child: {40'h5123840765, 40'h3123084765, 40'h7123864705, 40'h1103824765},
                cmove: {3'd4, 3'd3, 3'd2, 3'd1}, done_cycle: 9, exp_err: 1'b0};
    vecs[1] = '{board: 40'h0012345678, last: 3'd3, depth: 8'd0, n_children: 1,
                child: {40'h0, 40'h0, 40'h0, 40'h3312045678},
                cmove: {3'd0, 3'd0, 3'd0, 3'd2}, done_cycle: 6, exp_err: 1'b0};
    vecs[2] = '{board: 40'h9123456780, last: 3'd0, depth: 8'd0, n_children: 0,
                child: '0, cmove: '0, done_cycle: 1, exp_err: 1'b1};
    vecs[3] = '{board: 40'h4123804765, last: 3'd0, depth: 8'd31, n_children: 0,
                child: '0, cmove: '0, done_cycle: 1, exp_err: 1'b0};
    vecs[4] = '{board: 40'h8213456780, last: 3'd2, depth: 8'd7, n_children: 1,
                child: {40'h0, 40'h0, 40'h0, 40'h7213456708},
                cmove: {3'd0, 3'd0, 3'd0, 3'd3}, done_cycle: 6, exp_err: 1'b0};

    rst_n        = 1'b0;
    in_valid     = 1'b0;
    in_board     = '0;
    in_last_move = '0;
    in_depth     = '0;
    out_ready    = 1'b1;
    goal_clr     = 1'b0;

    // Reset state.
    #12;
    check_output("rst_in_ready", 64'(in_ready), 64'd0);
    check_output("rst_out_valid", 64'(out_valid), 64'd0);
    check_output("rst_alu_op", 64'(alu_op), 64'd0);
    check_output("rst_done", 64'(done), 64'd0);
    check_output("rst_goal_found", 64'(goal_found), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_output("in_ready_after_reset", 64'(in_ready), 64'd1);

    // Table-driven parents.
    for (int i = 0; i < 5; i++) begin
      run_vector(vecs[i]);
    end

    // Consumer stall on the first child.
    out_ready = 1'b0;
    apply_stimulus(40'h4123804765, 3'd0, 8'd3);
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_output("stall_first_valid", 64'(seen), 64'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_output("stall_valid", 64'(out_valid), 64'd1);
      check_output("stall_board", 64'(out_board), 64'h1103824765);
      check_output("stall_move", 64'(out_move), 64'd1);
      check_output("stall_alu_op", 64'(alu_op), 64'(OP_COPY));
      check_output("stall_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_output("after_hs_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    check_output("second_child_valid", 64'(out_valid), 64'd1);
    check_output("second_child_board", 64'(out_board), 64'h7123864705);
    check_output("second_child_move", 64'(out_move), 64'd2);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check_output("stall_done", 64'(seen), 64'd1);

    // Asynchronous reset while a child is pending.
    out_ready = 1'b0;
    apply_stimulus(40'h4123804765, 3'd0, 8'd3);
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_output("midrst_valid_before", 64'(seen), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("midrst_out_valid", 64'(out_valid), 64'd0);
    check_output("midrst_done", 64'(done), 64'd0);
    check_output("midrst_goal_found", 64'(goal_found), 64'd0);
    check_output("midrst_in_ready", 64'(in_ready), 64'd0);
    check_output("midrst_alu_op", 64'(alu_op), 64'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    check_output("midrst_in_ready_release", 64'(in_ready), 64'd1);
    @(negedge clk);
    check_output("midrst_no_done", 64'(done), 64'd0);
    check_output("midrst_no_valid", 64'(out_valid), 64'd0);

    // Goal parent: sticky flag blocks input until cleared.
    apply_stimulus(40'h8123456780, 3'd0, 8'd0);
    @(negedge clk);
    check_output("goal_done", 64'(done), 64'd1);
    check_output("goal_found_set", 64'(goal_found), 64'd1);
    check_output("goal_no_valid", 64'(out_valid), 64'd0);
    in_valid     = 1'b1;
    in_board     = 40'h4123804765;
    in_last_move = 3'd0;
    in_depth     = 8'd3;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_output("goal_blocks_ready", 64'(in_ready), 64'd0);
      check_output("goal_blocks_valid", 64'(out_valid), 64'd0);
    end
    in_valid = 1'b0;
    goal_clr = 1'b1;
    @(negedge clk);
    goal_clr = 1'b0;
    check_output("goal_clr_flag", 64'(goal_found), 64'd0);
    check_output("goal_clr_ready", 64'(in_ready), 64'd1);

    // Clear in the same cycle as the goal detection wins.
    apply_stimulus(40'h8123456780, 3'd0, 8'd0);
    goal_clr = 1'b1;
    @(negedge clk);
    goal_clr = 1'b0;
    check_output("clr_prio_done", 64'(done), 64'd1);
    check_output("clr_prio_flag", 64'(goal_found), 64'd0);
    check_output("clr_prio_ready", 64'(in_ready), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
